// File: rtl/prog_imem_pkg.sv
// Shared definitions for the program instruction memory: loader FSM states,
// the default no-op instruction and the width helpers used by every file.
package prog_imem_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVF  = 2'd2
    } imem_state_e;

    // RISC-V "addi x0, x0, 0"
    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0013;

    // Address width of a DEPTH-entry array (at least one bit).
    function automatic int unsigned addr_w(input int unsigned depth);
        if (depth > 32'd1) begin
            return $clog2(depth);
        end else begin
            return 32'd1;
        end
    endfunction

    // Width of a word counter able to hold 0..DEPTH inclusive.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth) + 32'd1;
    endfunction

    // Byte-address bits below the word index.
    function automatic int unsigned lane_shift(input int unsigned xlen);
        return $clog2(xlen / 32'd8);
    endfunction

    // Width of the byte-lane counter (at least one bit).
    function automatic int unsigned lane_w(input int unsigned xlen);
        if (lane_shift(xlen) > 32'd0) begin
            return lane_shift(xlen);
        end else begin
            return 32'd1;
        end
    endfunction

endpackage

// File: rtl/prog_imem_ram.sv
// Storage array for the program: one write port, one synchronous read port.
// No reset and no initial contents so it maps onto block RAM.
module imem_ram
    import prog_imem_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 256,
    localparam int unsigned AW   = addr_w(DEPTH)
) (
    input  logic            clk,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic            re_i,
    input  logic [AW-1:0]   raddr_i,
    output logic [XLEN-1:0] rdata_o
);

    logic [XLEN-1:0] mem_q [DEPTH];
    logic [XLEN-1:0] rdata_q;

    // Write port: store an assembled program word.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read port: registered read, one cycle after the request.
    always_ff @(posedge clk) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/prog_imem.sv
// Program instruction memory: assembles a little-endian byte stream into
// words, holds the core in reset until a complete program is loaded, then
// serves 1-cycle-latency instruction fetches with range/alignment checking.
module prog_imem
    import prog_imem_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 256,
    parameter logic [XLEN-1:0] NOP_WORD = XLEN'(NOP_WORD_DEFAULT)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ld_valid,
    input  logic [7:0]              ld_data,
    input  logic                    ld_last,
    output logic                    ld_ready,
    input  logic                    reload,
    output logic                    core_hold,
    input  logic                    fetch_en,
    input  logic [XLEN-1:0]         fetch_addr,
    output logic [XLEN-1:0]         fetch_instr,
    output logic                    fetch_valid,
    output logic                    fetch_err,
    output logic [$clog2(DEPTH):0]  load_words,
    output logic                    load_ovf
);

    localparam int unsigned LANES = XLEN / 32'd8;
    localparam int unsigned LSH   = lane_shift(XLEN);
    localparam int unsigned LW    = lane_w(XLEN);
    localparam int unsigned AW    = addr_w(DEPTH);
    localparam int unsigned CNT_W = cnt_w(DEPTH);
    localparam int unsigned CMP_W = (XLEN > CNT_W) ? XLEN : CNT_W;

    imem_state_e      state_q, state_d;
    logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]    byte_cnt_q, byte_cnt_d;
    logic [XLEN-1:0]  wbuf_q, wbuf_d;
    logic [CNT_W-1:0] load_words_q, load_words_d;
    logic             load_ovf_q, load_ovf_d;
    logic             ld_ready_q, ld_ready_d;
    logic             core_hold_q, core_hold_d;
    logic             fetch_valid_q, fetch_valid_d;
    logic             fetch_err_q, fetch_err_d;

    logic             accept_s;
    logic             last_lane_s;
    logic [XLEN-1:0]  asm_word_s;
    logic             ram_we_s;
    logic             ram_re_s;
    logic [XLEN-1:0]  ram_rdata_s;
    logic [XLEN-1:0]  idx_s;
    logic             misal_s;
    logic             oor_s;
    logic             fetch_req_s;

    // State and status registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_LOAD;
            wr_ptr_q      <= {CNT_W{1'b0}};
            byte_cnt_q    <= {LW{1'b0}};
            wbuf_q        <= {XLEN{1'b0}};
            load_words_q  <= {CNT_W{1'b0}};
            load_ovf_q    <= 1'b0;
            ld_ready_q    <= 1'b1;
            core_hold_q   <= 1'b1;
            fetch_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            byte_cnt_q    <= byte_cnt_d;
            wbuf_q        <= wbuf_d;
            load_words_q  <= load_words_d;
            load_ovf_q    <= load_ovf_d;
            ld_ready_q    <= ld_ready_d;
            core_hold_q   <= core_hold_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_err_q   <= fetch_err_d;
        end
    end

    // Loader FSM: byte assembly, word write-back, end-of-program and overflow.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        byte_cnt_d   = byte_cnt_q;
        wbuf_d       = wbuf_q;
        load_words_d = load_words_q;
        load_ovf_d   = load_ovf_q;
        ram_we_s     = 1'b0;
        accept_s     = ld_valid && ld_ready_q;
        last_lane_s  = (byte_cnt_q == LW'(LANES - 32'd1));
        // Lanes above the current one are already zero: the buffer is
        // cleared after every word write, so a partial word is zero-padded.
        asm_word_s   = wbuf_q;
        asm_word_s[{byte_cnt_q, 3'b000} +: 8] = ld_data;

        if (reload) begin
            // Restart the load; any byte offered this cycle is dropped and
            // the memory array itself is left untouched.
            state_d      = ST_LOAD;
            wr_ptr_d     = {CNT_W{1'b0}};
            byte_cnt_d   = {LW{1'b0}};
            wbuf_d       = {XLEN{1'b0}};
            load_words_d = {CNT_W{1'b0}};
            load_ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (accept_s) begin
                        if (wr_ptr_q == CNT_W'(DEPTH)) begin
                            load_ovf_d = 1'b1;
                            state_d    = ST_OVF;
                        end else if (last_lane_s || ld_last) begin
                            ram_we_s   = 1'b1;
                            wr_ptr_d   = wr_ptr_q + CNT_W'(1);
                            byte_cnt_d = {LW{1'b0}};
                            wbuf_d     = {XLEN{1'b0}};
                            if (ld_last) begin
                                load_words_d = wr_ptr_q + CNT_W'(1);
                                state_d      = ST_RUN;
                            end else begin
                                state_d      = ST_LOAD;
                            end
                        end else begin
                            wbuf_d     = asm_word_s;
                            byte_cnt_d = byte_cnt_q + LW'(1);
                        end
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
                ST_RUN: begin
                    state_d = ST_RUN;
                end
                ST_OVF: begin
                    // Bytes are sunk; only reload or reset leaves this state.
                    state_d = ST_OVF;
                end
                default: begin
                    state_d = ST_LOAD;
                end
            endcase
        end

        ld_ready_d  = (state_d != ST_RUN);
        core_hold_d = (state_d != ST_RUN);
    end

    // Fetch decode: word index, alignment and range checks, RAM read enable.
    always_comb begin
        idx_s         = fetch_addr >> LSH;
        misal_s       = ((fetch_addr & XLEN'(LANES - 32'd1)) != {XLEN{1'b0}});
        oor_s         = (CMP_W'(idx_s) >= CMP_W'(load_words_q));
        fetch_req_s   = fetch_en && !core_hold_q;
        ram_re_s      = fetch_req_s && !misal_s && !oor_s;
        fetch_valid_d = fetch_req_s;
        fetch_err_d   = fetch_req_s && (misal_s || oor_s);
    end

    imem_ram #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we_s),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (asm_word_s),
        .re_i    (ram_re_s),
        .raddr_i (idx_s[AW-1:0]),
        .rdata_o (ram_rdata_s)
    );

    assign ld_ready    = ld_ready_q;
    assign core_hold   = core_hold_q;
    assign load_words  = load_words_q;
    assign load_ovf    = load_ovf_q;
    assign fetch_valid = fetch_valid_q;
    assign fetch_err   = fetch_err_q;
    // Errored fetches return the no-op; nothing is driven when idle.
    assign fetch_instr = fetch_valid_q ? (fetch_err_q ? NOP_WORD : ram_rdata_s)
                                       : {XLEN{1'b0}};

endmodule

// File: tb/tb_prog_imem.sv
// Self-checking bench for prog_imem (DEPTH=4 so overflow is reachable).
// Reference model: a byte queue per load, turned into words by plain
// little-endian packing, plus the number of fetchable words.
module tb_prog_imem;

    localparam int DEPTH = 4;
    localparam int CAP   = DEPTH * 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_valid, ld_last, reload, fetch_en;
    logic [7:0]  ld_data;
    logic [31:0] fetch_addr;
    logic        ld_ready, core_hold, fetch_valid, fetch_err, load_ovf;
    logic [31:0] fetch_instr;
    logic [2:0]  load_words;

    int total = 0;
    int bad   = 0;

    logic [31:0] mdl_mem [DEPTH];
    int          mdl_words;
    logic [7:0]  bq [$];

    prog_imem #(.XLEN(32), .DEPTH(DEPTH), .NOP_WORD(32'h0000_0013)) dut (
        .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_last(ld_last), .ld_ready(ld_ready), .reload(reload),
        .core_hold(core_hold), .fetch_en(fetch_en), .fetch_addr(fetch_addr),
        .fetch_instr(fetch_instr), .fetch_valid(fetch_valid),
        .fetch_err(fetch_err), .load_words(load_words), .load_ovf(load_ovf)
    );

    always #5 clk = ~clk;

    function automatic bit exp_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> 2) >= 32'(mdl_words));
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        if (exp_err(a)) return NOP;
        return mdl_mem[a >> 2];
    endfunction

    // Pack the streamed bytes into words as the loader should have written them.
    task automatic model_load(input bit with_last);
        int n = bq.size();
        int nw;
        logic [31:0] w;
        if (n > CAP)        nw = DEPTH;
        else if (with_last) nw = (n + 3) / 4;
        else                nw = n / 4;
        for (int i = 0; i < nw; i++) begin
            w = 32'h0;
            for (int b = 0; b < 4; b++)
                if (4 * i + b < n) w[8 * b +: 8] = bq[4 * i + b];
            mdl_mem[i] = w;
        end
        if (n <= CAP && with_last) mdl_words = nw;
        else                       mdl_words = 0;
    endtask

    task automatic fill_random(input int n);
        bq.delete();
        for (int i = 0; i < n; i++) bq.push_back(8'($urandom));
    endtask

    task automatic fill_spec_program();
        bq = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    endtask

    // Stream bq into the loader with random idle gaps; optionally request
    // fetches throughout, which must all be ignored while held.
    task automatic send_stream(input bit with_last, input int gap_max, input bit noise);
        int sz = bq.size();
        for (int i = 0; i < sz; i++) begin
            repeat ($urandom_range(0, gap_max)) begin
                ld_valid = 1'b0; ld_last = 1'b0;
                fetch_en = noise; fetch_addr = 32'($urandom_range(0, 3) * 4);
                @(negedge clk);
                if (noise) begin
                    total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL load_fetch_gap got=%b want=0", fetch_valid); end
                end
            end
            ld_valid = 1'b1; ld_data = bq[i]; ld_last = with_last && (i == sz - 1);
            fetch_en = noise; fetch_addr = 32'($urandom_range(0, 3) * 4);
            @(negedge clk);
            if (noise) begin
                total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL load_fetch_byte got=%b want=0", fetch_valid); end
            end
        end
        ld_valid = 1'b0; ld_last = 1'b0; fetch_en = 1'b0;
        model_load(with_last);
    endtask

    task automatic pulse_reload(input bit inflight);
        reload = 1'b1;
        ld_valid = inflight; ld_data = 8'($urandom); ld_last = 1'b0;
        @(negedge clk);
        reload = 1'b0; ld_valid = 1'b0;
        mdl_words = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; ld_valid = 1'b0; ld_last = 1'b0; ld_data = 8'h00;
        reload = 1'b0; fetch_en = 1'b0; fetch_addr = 32'h0;
        mdl_words = 0;
        #2 rst = 1'b0;
        #1;
        total++; if (ld_ready !== 1'b1)     begin bad++; $display("FAIL rst_ld_ready got=%b want=1", ld_ready); end
        total++; if (core_hold !== 1'b1)    begin bad++; $display("FAIL rst_core_hold got=%b want=1", core_hold); end
        total++; if (load_words !== 3'd0)   begin bad++; $display("FAIL rst_load_words got=%0d want=0", load_words); end
        total++; if (load_ovf !== 1'b0)     begin bad++; $display("FAIL rst_load_ovf got=%b want=0", load_ovf); end
        total++; if ({fetch_valid, fetch_err} !== 2'b00) begin bad++; $display("FAIL rst_fetch_flags got=%b want=00", {fetch_valid, fetch_err}); end
        total++; if (fetch_instr !== 32'h0) begin bad++; $display("FAIL rst_fetch_instr got=%h want=0", fetch_instr); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_load();
        fill_spec_program();
        send_stream(1'b1, 0, 1'b0);
        total++; if (load_words !== 3'd2) begin bad++; $display("FAIL basic_words got=%0d want=2", load_words); end
        total++; if (core_hold !== 1'b0)  begin bad++; $display("FAIL basic_hold got=%b want=0", core_hold); end
        total++; if (ld_ready !== 1'b0)   begin bad++; $display("FAIL basic_ready got=%b want=0", ld_ready); end
        fetch_en = 1'b1; fetch_addr = 32'h0;
        @(negedge clk);
        total++; if ({fetch_valid, fetch_err} !== 2'b10) begin bad++; $display("FAIL basic_f0_flags got=%b want=10", {fetch_valid, fetch_err}); end
        total++; if (fetch_instr !== 32'h0010_0513) begin bad++; $display("FAIL basic_f0 got=%h want=00100513", fetch_instr); end
        fetch_en = 1'b0;
        @(negedge clk);
        total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL basic_idle got=%b want=0", fetch_valid); end
        fetch_en = 1'b1; fetch_addr = 32'h4;
        @(negedge clk);
        total++; if (fetch_instr !== 32'h0020_0593 || fetch_valid !== 1'b1) begin bad++; $display("FAIL basic_f4 got=%h/%b want=00200593/1", fetch_instr, fetch_valid); end
        fetch_en = 1'b0;
    endtask

    task automatic test_partial_and_errors();
        pulse_reload(1'b0);
        fill_random(5);
        send_stream(1'b1, 0, 1'b0);
        total++; if (load_words !== 3'd2) begin bad++; $display("FAIL partial_words got=%0d want=2", load_words); end
        fetch_en = 1'b1; fetch_addr = 32'h4;
        @(negedge clk);
        total++; if (fetch_instr !== {24'h0, bq[4]} || fetch_err !== 1'b0) begin bad++; $display("FAIL partial_w1 got=%h/%b want=%h/0", fetch_instr, fetch_err, {24'h0, bq[4]}); end
        fetch_addr = 32'h2;
        @(negedge clk);
        total++; if (fetch_instr !== NOP || fetch_err !== 1'b1 || fetch_valid !== 1'b1) begin bad++; $display("FAIL misalign got=%h/%b want=%h/1", fetch_instr, fetch_err, NOP); end
        fetch_addr = 32'h8;
        @(negedge clk);
        total++; if (fetch_instr !== NOP || fetch_err !== 1'b1) begin bad++; $display("FAIL range got=%h/%b want=%h/1", fetch_instr, fetch_err, NOP); end
        fetch_addr = 32'h40;
        @(negedge clk);
        total++; if (fetch_instr !== NOP || fetch_err !== 1'b1) begin bad++; $display("FAIL range_far got=%h/%b want=%h/1", fetch_instr, fetch_err, NOP); end
        fetch_en = 1'b0;
        @(negedge clk);
        total++; if ({fetch_valid, fetch_err} !== 2'b00) begin bad++; $display("FAIL err_clear got=%b want=00", {fetch_valid, fetch_err}); end
    endtask

    task automatic test_overflow();
        pulse_reload(1'b0);
        fill_random(CAP + 1);
        send_stream(1'b0, 1, 1'b0);
        total++; if (load_ovf !== 1'b1)   begin bad++; $display("FAIL ovf_flag got=%b want=1", load_ovf); end
        total++; if (core_hold !== 1'b1 || ld_ready !== 1'b1) begin bad++; $display("FAIL ovf_hold got=%b%b want=11", core_hold, ld_ready); end
        total++; if (load_words !== 3'd0) begin bad++; $display("FAIL ovf_words got=%0d want=0", load_words); end
        // A last byte while overflowed is sunk; the FSM must stay put.
        ld_valid = 1'b1; ld_last = 1'b1; ld_data = 8'hAA; fetch_en = 1'b1; fetch_addr = 32'h0;
        @(negedge clk);
        ld_valid = 1'b0; ld_last = 1'b0;
        @(negedge clk);
        total++; if (core_hold !== 1'b1 || load_ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b%b want=11", core_hold, load_ovf); end
        total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL ovf_fetch got=%b want=0", fetch_valid); end
        fetch_en = 1'b0;
        pulse_reload(1'b1);
        total++; if (load_ovf !== 1'b0 || load_words !== 3'd0 || core_hold !== 1'b1) begin bad++; $display("FAIL reload_clear got=%b/%0d/%b want=0/0/1", load_ovf, load_words, core_hold); end
        fill_random(4);
        send_stream(1'b1, 0, 1'b0);
        total++; if (load_words !== 3'd1 || core_hold !== 1'b0) begin bad++; $display("FAIL reload_load got=%0d/%b want=1/0", load_words, core_hold); end
        fetch_en = 1'b1; fetch_addr = 32'h0;
        @(negedge clk);
        total++; if (fetch_instr !== exp_word(32'h0)) begin bad++; $display("FAIL reload_w0 got=%h want=%h", fetch_instr, exp_word(32'h0)); end
        fetch_addr = 32'h4;
        @(negedge clk);
        total++; if (fetch_err !== 1'b1) begin bad++; $display("FAIL reload_w1_err got=%b want=1", fetch_err); end
        fetch_en = 1'b0;
    endtask

    task automatic test_reset_midload();
        pulse_reload(1'b0);
        fill_random(3);
        send_stream(1'b0, 0, 1'b0);
        #2 rst = 1'b0;
        #1;
        mdl_words = 0;
        total++; if (ld_ready !== 1'b1 || core_hold !== 1'b1) begin bad++; $display("FAIL mid_rst_hold got=%b%b want=11", ld_ready, core_hold); end
        total++; if (load_words !== 3'd0 || load_ovf !== 1'b0) begin bad++; $display("FAIL mid_rst_status got=%0d/%b want=0/0", load_words, load_ovf); end
        total++; if (fetch_valid !== 1'b0 || fetch_err !== 1'b0 || fetch_instr !== 32'h0) begin bad++; $display("FAIL mid_rst_fetch got=%b%b/%h want=00/0", fetch_valid, fetch_err, fetch_instr); end
        @(negedge clk);
        rst = 1'b1;
        fill_spec_program();
        send_stream(1'b1, 0, 1'b0);
        total++; if (load_words !== 3'd2) begin bad++; $display("FAIL mid_reload_words got=%0d want=2", load_words); end
        fetch_en = 1'b1; fetch_addr = 32'h0;
        @(negedge clk);
        total++; if (fetch_instr !== 32'h0010_0513) begin bad++; $display("FAIL mid_f0 got=%h want=00100513", fetch_instr); end
        fetch_addr = 32'h4;
        @(negedge clk);
        total++; if (fetch_instr !== 32'h0020_0593) begin bad++; $display("FAIL mid_f4 got=%h want=00200593", fetch_instr); end
        fetch_en = 1'b0;
    endtask

    task automatic test_gapped_load();
        pulse_reload(1'b0);
        fill_random(4);
        send_stream(1'b1, 3, 1'b1);
        total++; if (load_words !== 3'd1 || core_hold !== 1'b0) begin bad++; $display("FAIL gap_status got=%0d/%b want=1/0", load_words, core_hold); end
        fetch_en = 1'b1; fetch_addr = 32'h0;
        @(negedge clk);
        total++; if (fetch_instr !== {bq[3], bq[2], bq[1], bq[0]}) begin bad++; $display("FAIL gap_word got=%h want=%h", fetch_instr, {bq[3], bq[2], bq[1], bq[0]}); end
        fetch_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic        en;
        logic [31:0] a;
        int          words_before;
        for (int it = 0; it < 6; it++) begin
            pulse_reload(1'b0);
            fill_random($urandom_range(1, CAP));
            send_stream(1'b1, 2, 1'b0);
            total++; if (load_words !== 3'(mdl_words) || core_hold !== 1'b0) begin bad++; $display("FAIL rnd_load got=%0d/%b want=%0d/0", load_words, core_hold, mdl_words); end
            words_before = mdl_words;
            for (int c = 0; c < 30; c++) begin
                en = ($urandom_range(0, 3) != 0);
                a  = 32'($urandom_range(0, DEPTH + 1) * 4);
                if ($urandom_range(0, 4) == 0) a = a + 32'($urandom_range(1, 3));
                fetch_en = en; fetch_addr = a;
                // Loader traffic while running must be ignored.
                ld_valid = $urandom_range(0, 1); ld_last = $urandom_range(0, 1); ld_data = 8'($urandom);
                @(negedge clk);
                total++; if (fetch_valid !== en) begin bad++; $display("FAIL rnd_valid a=%h got=%b want=%b", a, fetch_valid, en); end
                total++; if (fetch_err !== (en && exp_err(a))) begin bad++; $display("FAIL rnd_err a=%h got=%b want=%b", a, fetch_err, en && exp_err(a)); end
                if (en) begin
                    total++; if (fetch_instr !== exp_word(a)) begin bad++; $display("FAIL rnd_instr a=%h got=%h want=%h", a, fetch_instr, exp_word(a)); end
                end
            end
            fetch_en = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
            @(negedge clk);
            total++; if (load_words !== 3'(words_before) || ld_ready !== 1'b0) begin bad++; $display("FAIL rnd_run_stable got=%0d/%b want=%0d/0", load_words, ld_ready, words_before); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_partial_and_errors();
        test_overflow();
        test_reset_midload();
        test_gapped_load();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prog_imem.md
PROG_IMEM -- requirements
Module: prog_imem

Interface
REQ-001 Parameter XLEN, default 32: instruction word width in bits, a multiple of 8.
REQ-002 Parameter DEPTH, default 256: number of instruction words stored.
REQ-003 Parameter NOP_WORD, default 32'h00000013: word returned for unloaded or invalid fetches.
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 ld_valid  in  1  loader byte strobe.
REQ-007 ld_data  in  8  program byte, little-endian order within each word.
REQ-008 ld_last  in  1  marks the final program byte; qualified by ld_valid.
REQ-009 ld_ready  out  1  the block accepts a byte when ld_valid and ld_ready are both high.
REQ-010 reload  in  1  one-cycle pulse that restarts program load.
REQ-011 core_hold  out  1  high = hold the core in reset; program not runnable.
REQ-012 fetch_en  in  1  fetch request.
REQ-013 fetch_addr  in  XLEN  fetch byte address.
REQ-014 fetch_instr  out  XLEN  fetched word.
REQ-015 fetch_valid  out  1  fetch_instr is valid this cycle.
REQ-016 fetch_err  out  1  the current fetch was misaligned or out of range.
REQ-017 load_words  out  clog2(DEPTH)+1  number of words written by the last load.
REQ-018 load_ovf  out  1  sticky flag: a program byte arrived after the memory was full.

Function
REQ-019 FSM states LOAD, RUN, OVF; reset enters LOAD.
REQ-020 LOAD: ld_ready=1, core_hold=1; each accepted byte goes into lane byte_cnt of a word buffer; byte_cnt counts 0..XLEN/8-1 and wraps.
REQ-021 When the last lane is accepted, the assembled word is written to mem[wr_ptr] in that cycle and wr_ptr increments by 1.
REQ-022 Accepted byte with ld_last=1: the partial word is written with unfilled lanes zero; load_words becomes wr_ptr+1; the FSM moves to RUN on the next edge.
REQ-023 ld_last arriving on an exact word boundary writes no extra word.
REQ-024 Accepted byte while wr_ptr==DEPTH: the byte is discarded, load_ovf is set, the FSM moves to OVF.
REQ-025 OVF: ld_ready=1 and bytes are sunk; core_hold=1; only reload or reset leaves OVF.
REQ-026 RUN: ld_ready=0, core_hold=0; fetch is active.
REQ-027 reload in any state: the FSM moves to LOAD; wr_ptr, byte_cnt, load_words and load_ovf clear; memory contents are kept; any in-flight byte in that cycle is dropped.
REQ-028 Fetch latency is 1 cycle: fetch_en at edge N gives fetch_valid=1 plus data after edge N+1; fetch_valid=0 when fetch_en is low.
REQ-029 A fetch is ignored (fetch_valid=0) while core_hold=1.
REQ-030 Word index = fetch_addr >> clog2(XLEN/8).
REQ-031 The fetch returns NOP_WORD with fetch_err=1 if the low address bits are nonzero or the index is >= load_words.
REQ-032 fetch_err is registered alongside fetch_valid and is 0 when fetch_valid=0.
REQ-033 Memory is inferred as synchronous-read block RAM with one write port and one read port; no memory initialisation is relied upon.

Reset
REQ-034 rst low: state=LOAD, wr_ptr=0, byte_cnt=0, load_words=0, load_ovf=0, fetch_valid=0, fetch_err=0, fetch_instr=0, ld_ready=1, core_hold=1.
REQ-035 Reset mid-load abandons the load; memory contents are undefined but are never fetched, because load_words=0.

Structure
REQ-036 A shared package holds the FSM state enum, NOP_WORD, and the address/index width functions.
REQ-037 One sub-module, imem_ram (parametrised XLEN/DEPTH, synchronous read), encapsulates the storage array.

Verification
REQ-038 Stream 8 bytes 13 05 10 00 | 93 05 20 00 with ld_last on the 8th -> load_words=2, core_hold falls; fetch 0x0 -> 0x00100513, fetch 0x4 -> 0x00200593, 1-cycle latency.
REQ-039 Stream 5 bytes with ld_last on the 5th -> load_words=2; word1 = 0x000000<b4>.
REQ-040 Fetch 0x2, and fetch 0x8 with load_words=2 -> NOP 0x00000013 with fetch_err=1.
REQ-041 DEPTH=4: stream 17 bytes -> load_ovf=1, state OVF, core_hold stays 1; reload then a 4-byte load -> RUN, load_words=1.
REQ-042 Assert rst low after the 3rd byte -> all REQ-034 values immediately; a subsequent full load behaves as REQ-038.
REQ-043 Gap ld_valid randomly across 4 bytes, and apply fetch_en during LOAD -> the word is assembled correctly and fetch_valid stays 0 until RUN.
